// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program-counter generator:
// state encoding, PC-stage stall index and the alignment helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  localparam int PC_STALL_BIT = 0;

  // log2 of a power-of-two instruction size; gives the number of PC bits
  // that must be zero for an aligned fetch address.
  function automatic int align_bits(input int inst_bytes);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) == inst_bytes) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Bundle of redirect sources, fetch handshake and PC outputs of pc_gen.
// Fetch handshake: a fetch at pc is issued when fetch_valid_o && fetch_ready_i
// at a rising edge; pc advances only then and only while not stalled.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6,
  parameter int EPOCH_W = 2
);
  import pc_gen_pkg::*;

  logic [STALL_W-1:0] stall;
  logic               branch_taken_i;
  logic [ADDR_W-1:0]  branch_addr_i;
  logic               trap_valid_i;
  logic [ADDR_W-1:0]  trap_addr_i;
  logic               fetch_ready_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               fetch_valid_o;
  logic [EPOCH_W-1:0] epoch_o;
  logic               restart;
  logic               misalign_o;
  pc_state_e          state_dbg;

  modport master (
    output stall, branch_taken_i, branch_addr_i, trap_valid_i, trap_addr_i, fetch_ready_i,
    input  pc, ce, fetch_valid_o, epoch_o, restart, misalign_o, state_dbg
  );

  modport slave (
    input  stall, branch_taken_i, branch_addr_i, trap_valid_i, trap_addr_i, fetch_ready_i,
    output pc, ce, fetch_valid_o, epoch_o, restart, misalign_o, state_dbg
  );

endinterface

// File: rtl/pc_gen_redirect_arb.sv
// Combinational redirect arbitration: trap > aligned branch > pending.
// A misaligned branch is flagged and dropped unless a trap overrides it.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = 4
) (
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic [ADDR_W-1:0] target,
  output logic              redirect_valid,
  output logic              is_new,
  output logic              misalign
);

  localparam int                AB         = align_bits(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << AB) - 1);

  logic branch_misaligned;
  assign branch_misaligned = |(branch_addr & ALIGN_MASK);

  always_comb begin
    target         = '0;
    redirect_valid = 1'b0;
    is_new         = 1'b0;
    misalign       = 1'b0;
    if (trap_valid) begin
      target         = trap_addr & ~ALIGN_MASK;
      redirect_valid = 1'b1;
      is_new         = 1'b1;
    end else if (branch_taken && !branch_misaligned) begin
      target         = branch_addr;
      redirect_valid = 1'b1;
      is_new         = 1'b1;
    end else begin
      misalign = branch_taken;
      if (pend_valid) begin
        target         = pend_addr;
        redirect_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: fetch handshake, trap/branch redirects with a
// buffered redirect during stalls, and an epoch tag for stale-fetch discard.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                STALL_W    = 6,
  parameter int                EPOCH_W    = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  pc_state_e          state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pend_addr_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               ce_q;
  logic               fetch_valid_q;
  logic               restart_q;
  logic               misalign_q;

  logic               stall_pc;
  logic               unused_stall;
  logic [ADDR_W-1:0]  arb_target;
  logic               arb_valid;
  logic               arb_is_new;
  logic               arb_misalign;

  assign stall_pc     = bus.stall[PC_STALL_BIT];
  assign unused_stall = ^bus.stall;

  pc_redirect_arb #(
    .ADDR_W    (ADDR_W),
    .INST_BYTES(INST_BYTES)
  ) u_arb (
    .trap_valid    (bus.trap_valid_i),
    .trap_addr     (bus.trap_addr_i),
    .branch_taken  (bus.branch_taken_i),
    .branch_addr   (bus.branch_addr_i),
    .pend_valid    (state_q == ST_PEND),
    .pend_addr     (pend_addr_q),
    .target        (arb_target),
    .redirect_valid(arb_valid),
    .is_new        (arb_is_new),
    .misalign      (arb_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VEC;
      pend_addr_q   <= '0;
      epoch_q       <= '0;
      ce_q          <= 1'b0;
      fetch_valid_q <= 1'b0;
      restart_q     <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q       <= ST_RUN;
          ce_q          <= 1'b1;
          fetch_valid_q <= 1'b1;
          restart_q     <= 1'b0;
          misalign_q    <= 1'b0;
        end
        default: begin
          restart_q  <= 1'b0;
          misalign_q <= arb_misalign;
          if (arb_valid && arb_is_new) begin
            // Every new redirect bumps the epoch, even one parked in PEND,
            // so fetches issued before it are recognisably stale.
            epoch_q <= epoch_q + EPOCH_W'(1);
            if (stall_pc) begin
              pend_addr_q   <= arb_target;
              state_q       <= ST_PEND;
              fetch_valid_q <= 1'b0;
            end else begin
              pc_q          <= arb_target;
              restart_q     <= 1'b1;
              state_q       <= ST_RUN;
              fetch_valid_q <= 1'b1;
            end
          end else if (arb_valid && !stall_pc) begin
            pc_q          <= arb_target;
            restart_q     <= 1'b1;
            state_q       <= ST_RUN;
            fetch_valid_q <= 1'b1;
          end else if (state_q == ST_RUN && !stall_pc && bus.fetch_ready_i) begin
            pc_q      <= pc_q + ADDR_W'(INST_BYTES);
            restart_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ce            = ce_q;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.epoch_o       = epoch_q;
  assign bus.restart       = restart_q;
  assign bus.misalign_o    = misalign_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic,
// all compared against a rule-level model of the PC generator.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int          ADDR_W     = 32;
  localparam int          STALL_W    = 6;
  localparam int          EPOCH_W    = 2;
  localparam int          INST_BYTES = 4;
  localparam logic [31:0] RESET_VEC  = 32'h0;
  localparam int          EXP_W      = ADDR_W + EPOCH_W + 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W), .EPOCH_W(EPOCH_W)) bus ();

  pc_gen #(
    .ADDR_W    (ADDR_W),
    .RESET_VEC (RESET_VEC),
    .INST_BYTES(INST_BYTES),
    .STALL_W   (STALL_W),
    .EPOCH_W   (EPOCH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  bit          m_started;
  logic [31:0] m_pc;
  int          m_epoch;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_restart;
  bit          m_misalign;
  bit          m_fetch_valid;
  bit          m_ce;

  function automatic logic [EXP_W-1:0] model_vec();
    pc_state_e st;
    if (!m_started)  st = ST_IDLE;
    else if (m_pend) st = ST_PEND;
    else             st = ST_RUN;
    return {m_pc, EPOCH_W'(m_epoch), m_restart, m_misalign, m_fetch_valid, m_ce, st};
  endfunction

  function automatic logic [EXP_W-1:0] observe();
    return {bus.pc, bus.epoch_o, bus.restart, bus.misalign_o, bus.fetch_valid_o, bus.ce,
            bus.state_dbg};
  endfunction

  task automatic model_step(input bit r, input bit s0, input bit bt, input logic [31:0] ba,
                            input bit tv, input logic [31:0] ta, input bit fr);
    bit          redirect;
    logic [31:0] tgt;
    if (r) begin
      m_started = 0; m_pc = RESET_VEC; m_epoch = 0; m_pend = 0; m_pend_addr = 0;
      m_restart = 0; m_misalign = 0; m_fetch_valid = 0; m_ce = 0;
      return;
    end
    if (!m_started) begin
      m_started = 1; m_ce = 1; m_fetch_valid = 1; m_restart = 0; m_misalign = 0;
      return;
    end
    m_restart  = 0;
    m_misalign = 0;
    redirect   = 0;
    tgt        = 0;
    if (tv) begin
      redirect = 1;
      tgt = ta - (ta % INST_BYTES);
    end else if (bt && (ba % INST_BYTES) == 0) begin
      redirect = 1;
      tgt = ba;
    end else if (bt) begin
      m_misalign = 1;
    end
    if (redirect) begin
      m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
      if (s0) begin
        m_pend = 1; m_pend_addr = tgt; m_fetch_valid = 0;
      end else begin
        m_pend = 0; m_pc = tgt; m_restart = 1; m_fetch_valid = 1;
      end
    end else if (m_pend) begin
      if (!s0) begin
        m_pend = 0; m_pc = m_pend_addr; m_restart = 1; m_fetch_valid = 1;
      end
    end else if (!s0 && fr) begin
      m_pc = m_pc + INST_BYTES;
      m_restart = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit s0, input bit bt, input logic [31:0] ba,
                       input bit tv, input logic [31:0] ta, input bit fr);
    logic [STALL_W-1:0] sv;
    sv = STALL_W'($urandom);
    sv[0] = s0;
    rst                = r;
    bus.stall          = sv;
    bus.branch_taken_i = bt;
    bus.branch_addr_i  = ba;
    bus.trap_valid_i   = tv;
    bus.trap_addr_i    = ta;
    bus.fetch_ready_i  = fr;
    model_step(r, s0, bt, ba, tv, ta, fr);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EXP_W-1:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL reset_state: got %h want %h", observe(), e);
      end
    end
    total++;
    if (bus.ce !== 1'b0 || bus.pc !== RESET_VEC || bus.fetch_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ce=%b pc=%h fv=%b want ce=0 pc=%h fv=0",
               bus.ce, bus.pc, bus.fetch_valid_o, RESET_VEC);
    end
  endtask

  task automatic test_release_advance();
    logic [EXP_W-1:0] e;
    logic [31:0] want_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      total++;
      if (observe() !== e || bus.pc !== want_pc[i]) begin
        bad++;
        $display("FAIL release_advance[%0d]: got %h want %h (pc want %h)", i, observe(), e,
                 want_pc[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [EXP_W-1:0] e;
    bit fr_tab[3] = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, fr_tab[i]);
      e = exp_q.pop_front();
      total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL backpressure[%0d]: got %h want %h", i, observe(), e);
      end
    end
    total++;
    if (bus.pc !== 32'h10 || bus.restart !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_resume: pc=%h restart=%b want pc=00000010 restart=1",
               bus.pc, bus.restart);
    end
  endtask

  task automatic test_stalled_branch();
    logic [EXP_W-1:0] e;
    drive(0, 1, 1, 32'h100, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      total++;
      if (i == 4 && observe() !== e) begin
        bad++;
        $display("FAIL stalled_branch_release: got %h want %h", observe(), e);
      end else if (i < 4 && e[EXP_W-1 -: ADDR_W] !== 32'h10) begin
        bad++;
        $display("FAIL stalled_branch_hold[%0d]: model pc %h want 00000010", i,
                 e[EXP_W-1 -: ADDR_W]);
      end
    end
    total++;
    if (bus.pc !== 32'h100 || bus.epoch_o !== 2'd1 || bus.restart !== 1'b1) begin
      bad++;
      $display("FAIL stalled_branch_pc: pc=%h epoch=%0d restart=%b want 100/1/1",
               bus.pc, bus.epoch_o, bus.restart);
    end
  endtask

  task automatic test_pend_window();
    logic [EXP_W-1:0] e;
    drive(0, 1, 1, 32'h400, 0, 0, 1);
    e = exp_q.pop_front();
    total++;
    if (observe() !== e || bus.fetch_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL pend_enter: got %h want %h", observe(), e);
    end
  endtask

  task automatic test_priority();
    logic [EXP_W-1:0] e;
    drive(0, 0, 1, 32'h100, 1, 32'h203, 1);
    e = exp_q.pop_front();
    total++;
    if (observe() !== e || bus.pc !== 32'h200) begin
      bad++;
      $display("FAIL trap_over_branch: got %h want %h", observe(), e);
    end
    drive(0, 0, 1, 32'h102, 0, 0, 1);
    e = exp_q.pop_front();
    total++;
    if (observe() !== e || bus.misalign_o !== 1'b1 || bus.pc !== 32'h204) begin
      bad++;
      $display("FAIL misaligned_branch: got %h want %h", observe(), e);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    e = exp_q.pop_front();
    total++;
    if (observe() !== e || bus.misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_pulse_end: got %h want %h", observe(), e);
    end
  endtask

  task automatic test_pend_replace();
    logic [EXP_W-1:0] e;
    drive(0, 1, 1, 32'h400, 0, 0, 1);
    drive(0, 1, 0, 0, 1, 32'h500, 1);
    drive(0, 0, 1, 32'h600, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      if (i == 2) begin
        total++;
        if (observe() !== e || bus.pc !== 32'h600) begin
          bad++;
          $display("FAIL pend_replace: got %h want %h", observe(), e);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [EXP_W-1:0] e;
    int ep_before;
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    total++;
    if (observe() !== e || bus.pc !== 32'h0) begin
      bad++;
      $display("FAIL pc_wrap: got %h want %h", observe(), e);
    end
    ep_before = m_epoch;
    for (int i = 1; i <= 4; i++) drive(0, 0, 1, 32'h1000 * i, 0, 0, 1);
    for (int i = 0; i < 4; i++) e = exp_q.pop_front();
    total++;
    if (observe() !== e || int'(bus.epoch_o) !== ep_before || bus.pc !== 32'h4000) begin
      bad++;
      $display("FAIL epoch_wrap: epoch=%0d pc=%h want epoch=%0d pc=00004000",
               bus.epoch_o, bus.pc, ep_before);
    end
  endtask

  task automatic test_reset_mid_pend();
    logic [EXP_W-1:0] e;
    drive(0, 1, 1, 32'h300, 0, 0, 1);
    void'(exp_q.pop_front());
    drive(1, 1, 0, 0, 0, 0, 1);
    e = exp_q.pop_front();
    total++;
    if (observe() !== e || bus.pc !== RESET_VEC || bus.state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_mid_pend: got %h want %h", observe(), e);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      total++;
      if (observe() !== e || bus.pc === 32'h300) begin
        bad++;
        $display("FAIL pend_lost[%0d]: got %h want %h", i, observe(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [EXP_W-1:0] e;
    logic [31:0] ba;
    for (int i = 0; i < 400; i++) begin
      ba = $urandom;
      if ($urandom_range(0, 3) != 0) ba = ba & 32'hFFFF_FFFC;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            ba, $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 2) != 0);
      e = exp_q.pop_front();
      total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, observe(), e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.stall = '0;
    bus.branch_taken_i = 1'b0;
    bus.branch_addr_i = '0;
    bus.trap_valid_i = 1'b0;
    bus.trap_addr_i = '0;
    bus.fetch_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_release_advance();
    test_backpressure();
    test_stalled_branch();
    test_pend_window();
    drive(0, 0, 0, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    test_priority();
    test_pend_replace();
    test_wrap();
    test_reset_mid_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage. Successor to the single-width PC register.
- Adds a fetch request/ready handshake, trap redirects that take priority over branches, a buffered redirect when a redirect arrives during a stall, an epoch tag for discarding stale fetches, and misaligned-target detection.
- Sits between the execute/CSR redirect sources and the instruction-fetch/memory interface.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 0, PC value after reset.
- INST_BYTES, 4, PC increment and alignment; must be a power of two.
- STALL_W, 6, width of the pipeline stall vector; only bit 0 (PC stage) is consumed.
- EPOCH_W, 2, width of the redirect epoch counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds the PC.
- branch_taken_i  in  1  branch redirect request.
- branch_addr_i  in  ADDR_W  branch target.
- trap_valid_i  in  1  trap/exception redirect request.
- trap_addr_i  in  ADDR_W  trap target; low log2(INST_BYTES) bits are forced to 0.
- fetch_ready_i  in  1  memory accepted the current fetch.
- pc  out  ADDR_W  current fetch address.
- ce  out  1  chip enable; 0 only in IDLE.
- fetch_valid_o  out  1  pc is a live fetch request.
- epoch_o  out  EPOCH_W  tag attached to issued fetches.
- restart  out  1  pulses on every cycle pc was updated by the last edge.
- misalign_o  out  1  one-cycle pulse: branch target was misaligned and dropped.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, pc=RESET_VEC, ce=0, fetch_valid_o=0, epoch_o=0, restart=0, misalign_o=0, pending redirect cleared. Reset also aborts a pending redirect.
- States:
  - IDLE: entered only by reset. First edge with rst=0 goes to RUN with ce=1 and pc unchanged (=RESET_VEC).
  - RUN: fetch_valid_o=1.
  - PEND: fetch_valid_o=0; pc is held.
- Event evaluation, each edge in RUN/PEND. The highest-priority active event wins: trap > branch > pending > advance.
- Redirect request: trap_valid_i, or branch_taken_i with an aligned target.
- Misaligned branch: branch_addr_i mod INST_BYTES != 0 with no trap in the same cycle. The branch is dropped, misalign_o=1 for one cycle, and epoch and pc are unchanged by it.
- Redirect with stall[0]=0:
  - pc<=target, restart=1, epoch_o<=epoch_o+1 (wraps mod 2^EPOCH_W), state RUN.
  - fetch_ready_i is ignored; the abandoned fetch is stale by epoch.
- Redirect with stall[0]=1:
  - Capture target into pend_addr, epoch_o+1, state PEND, restart=0, pc held.
  - A new redirect while in PEND replaces pend_addr and increments the epoch again.
- PEND with stall[0]=0 and no new redirect: pc<=pend_addr, restart=1, state RUN, epoch unchanged.
- PEND with stall[0]=0 and a new redirect in the same cycle: the new target is applied directly and the epoch increments.
- Advance (RUN, no redirect, stall[0]=0, fetch_ready_i=1): pc<=pc+INST_BYTES, wrapping mod 2^ADDR_W, restart=1.
- Otherwise: pc held, restart=0.
- Outputs are all registered; redirect-to-pc latency is 1 cycle.

Decomposition:
- Shared package/defines gets: state encodings (IDLE/RUN/PEND), stall-bit index for the PC stage, and the alignment-mask function log2(INST_BYTES).
- One natural sub-module, pc_redirect_arb: combinational priority arbitration of trap/branch/pending plus the misalignment check. It outputs the selected target, redirect_valid and is_new.
- The state, pc, pending and epoch registers stay in pc_gen.

Test Plan:
- Reset release: rst 1→0 → cycle 1: ce=1, pc=0x0, fetch_valid_o=1, epoch_o=0. With fetch_ready_i=1 for 3 cycles → pc 0x4, 0x8, 0xC, restart=1 each cycle.
- Backpressure: fetch_ready_i=0 for 2 cycles at pc=0x8 → pc stays 0x8, restart=0. Ready returns → pc=0xC.
- Stalled branch: stall[0]=1, branch 0x100 → PEND, fetch_valid_o=0, epoch 0→1. Stall held 3 cycles, then released → pc=0x100, restart=1, epoch stays 1.
- Priority: trap 0x200 and branch 0x100 in the same cycle → pc=0x200, epoch+1 only once. Branch 0x102 alone → misalign_o=1 for 1 cycle, pc advances normally.
- Wrap: ADDR_W=8, pc=0xFC, advance → pc=0x00. Four redirects with EPOCH_W=2 → epoch wraps to 0.
- Reset mid-PEND: rst=1 while in PEND with pend_addr 0x300 → pc=RESET_VEC, IDLE, pending lost. After release, pc never becomes 0x300.
